cacheline_arbiter: RTL and testbench
====================================

Name: cacheline_arbiter

Overview:
- Shares the single cacheline-wide physical memory port between two cache requesters: port 0 is the I-cache and port 1 is the D-cache.
- The downstream port feeds the cacheline adaptor / serializer-deserializer path that talks to main memory.
- Grants one whole transaction at a time using round-robin priority.
- Latches the winner's command and holds the grant until the downstream mem_resp.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- LINE_WIDTH, 256, cacheline data width in bits.
- BE_WIDTH, LINE_WIDTH/8, byte-enable width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req0_mem_address  in  ADDR_WIDTH  port 0 line address.
- req0_mem_read  in  1  port 0 read request.
- req0_mem_write  in  1  port 0 write request.
- req0_mem_wdata  in  LINE_WIDTH  port 0 write line.
- req0_mem_byte_enable  in  BE_WIDTH  port 0 byte enables.
- req0_mem_rdata  out  LINE_WIDTH  port 0 read line.
- req0_mem_resp  out  1  port 0 completion pulse.
- req1_*  same seven signals, same directions and widths, for port 1.
- pmem_mem_address  out  ADDR_WIDTH  downstream address.
- pmem_mem_read  out  1  downstream read strobe.
- pmem_mem_write  out  1  downstream write strobe.
- pmem_mem_wdata  out  LINE_WIDTH  downstream write line.
- pmem_mem_byte_enable  out  BE_WIDTH  downstream byte enables.
- pmem_mem_rdata  in  LINE_WIDTH  downstream read line.
- pmem_mem_resp  in  1  downstream completion pulse, one cycle.

Behaviour:
- States: IDLE, BUSY, RELEASE. A registered grant bit `gnt` names the served port. A registered `last` bit names the previously served port.
- Reset: state=IDLE, last=1 (port 0 wins the first tie). All pmem_* command outputs are 0. Both reqN_mem_resp are 0. Both reqN_mem_rdata are 0.
- A port is "requesting" when its mem_read or mem_write is 1.
- If a port asserts both read and write, write wins and the read is not forwarded.
- IDLE:
  - If only one port is requesting, grant it.
  - If both are requesting, grant the port that is not `last`.
  - On grant: latch address, wdata, byte_enable and read/write into output registers, set gnt, go to BUSY.
  - If no port is requesting, stay in IDLE with outputs 0.
- BUSY:
  - pmem_* outputs are driven from the latched registers. They stay stable even if the requester changes its inputs.
  - On pmem_mem_resp=1:
    - reqGNT_mem_resp=1 combinationally in the same cycle.
    - reqGNT_mem_rdata = pmem_mem_rdata combinationally in the same cycle.
    - Clear the pmem_mem_read/pmem_mem_write registers at the next edge.
    - last<=gnt; go to RELEASE.
- The non-granted port always sees resp=0 and rdata=0.
- RELEASE: exactly one cycle with no new grant. This gives the requester time to drop its strobe after the response, so a stale strobe is never re-granted. Then go to IDLE.
- Latency:
  - Request seen in IDLE at edge N → pmem strobe high from cycle N+1.
  - Response at cycle M → earliest next grant decided in IDLE at M+2 → next pmem strobe at M+3.
- Fairness: under continuous requests from both ports, grants strictly alternate 0,1,0,1…
- A requester that drops its request while in BUSY does not abort the transaction. It completes downstream, and the resp is still pulsed to that port.
- pmem_mem_resp outside BUSY is ignored: no reqN resp, no state change.
- rst asserted in any state: at that edge go to IDLE, last=1, and deassert all strobes. An in-flight transaction is abandoned and no resp is forwarded.

Test Plan:
- Reset, then no requests for 5 cycles → pmem_mem_read=pmem_mem_write=0, and both resp stay 0.
- Port 0 reads addr 0x0000_1000 alone; memory responds 4 cycles later with rdata 0xDEAD…BEEF → pmem_mem_read=1 with addr 0x1000 from cycle N+1; req0_mem_resp=1 for one cycle with matching rdata; req1_mem_resp stays 0.
- Both ports request at the same edge right after reset (port 0 read 0x100, port 1 write 0x200, byte_enable all-1) → port 0 is served first, then after RELEASE port 1's write appears with its wdata and byte enables.
- Both ports hold requests for 4 transactions → grant order is 0,1,0,1, and there is ≥1 RELEASE cycle between consecutive pmem strobes.
- Port 1 changes its address from 0x300 to 0x400 mid-BUSY → pmem_mem_address stays 0x300 until resp.
- rst pulsed mid-BUSY, then a spurious pmem_mem_resp → no reqN_mem_resp; after rst, a tie is granted to port 0.

Source files
------------

// File: rtl/cacheline_arbiter_if.sv
// Cacheline-wide memory port bundle: address, read/write strobes, write line,
// byte enables, read line and a one-cycle completion pulse.
//   master : issues commands (cache side, or the arbiter toward memory)
//   slave  : services commands (memory side, or the arbiter toward a cache)
interface cacheline_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int BE_WIDTH   = LINE_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_read;
    logic                  mem_write;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [BE_WIDTH-1:0]   mem_byte_enable;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport master (
        output mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_wdata, mem_byte_enable,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between the I-cache
// (req0) and the D-cache (req1); one whole transaction is granted at a time.
//   clk, rst : clock, synchronous active-high reset
//   req0     : I-cache port (slave side)
//   req1     : D-cache port (slave side)
//   pmem     : downstream memory port (master side)
module cacheline_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int BE_WIDTH   = LINE_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    cacheline_arbiter_if.slave    req0,
    cacheline_arbiter_if.slave    req1,
    cacheline_arbiter_if.master   pmem
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic                  last_q, last_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [BE_WIDTH-1:0]   be_q, be_d;

    logic v0, v1, pick, busy, fwd;

    assign v0 = req0.mem_read | req0.mem_write;
    assign v1 = req1.mem_read | req1.mem_write;

    // On a tie the port that was not served last wins.
    assign pick = (v0 & v1) ? ~last_q : v1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        unique case (state_q)
            IDLE: begin
                if (v0 | v1) begin
                    gnt_d   = pick;
                    state_d = BUSY;
                    if (pick) begin
                        addr_d  = req1.mem_address;
                        wdata_d = req1.mem_wdata;
                        be_d    = req1.mem_byte_enable;
                        wr_d    = req1.mem_write;
                        rd_d    = req1.mem_read & ~req1.mem_write;
                    end else begin
                        addr_d  = req0.mem_address;
                        wdata_d = req0.mem_wdata;
                        be_d    = req0.mem_byte_enable;
                        wr_d    = req0.mem_write;
                        rd_d    = req0.mem_read & ~req0.mem_write;
                    end
                end
            end
            BUSY: begin
                if (pmem.mem_resp) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    last_d  = gnt_q;
                    state_d = RELEASE;
                end
            end
            // One dead cycle lets the requester drop its strobe so the
            // just-served request is not granted a second time.
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign fwd  = busy & pmem.mem_resp;

    assign pmem.mem_address     = busy ? addr_q  : '0;
    assign pmem.mem_wdata       = busy ? wdata_q : '0;
    assign pmem.mem_byte_enable = busy ? be_q    : '0;
    assign pmem.mem_read        = busy & rd_q;
    assign pmem.mem_write       = busy & wr_q;

    assign req0.mem_resp  = fwd & ~gnt_q;
    assign req1.mem_resp  = fwd & gnt_q;
    assign req0.mem_rdata = req0.mem_resp ? pmem.mem_rdata : '0;
    assign req1.mem_rdata = req1.mem_resp ? pmem.mem_rdata : '0;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed testbench for cacheline_arbiter: vector table for per-cycle
// behaviour plus a hand-written fairness sequence with a bounded responder.
module tb_cacheline_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam int BW = LW / 8;

    localparam logic [LW-1:0] RDATA = {8{32'hDEAD_BEEF}};
    localparam logic [LW-1:0] WD0   = {8{32'h0000_A5A5}};
    localparam logic [LW-1:0] WD1   = {8{32'h1234_5678}};
    localparam logic [BW-1:0] BE0   = 32'h0000_FFFF;
    localparam logic [BW-1:0] BE1   = 32'hFFFF_FFFF;

    typedef struct {
        logic        rst;
        logic        rd0, wr0;
        logic [31:0] a0;
        logic        rd1, wr1;
        logic [31:0] a1;
        logic        presp;
        logic        eprd, epwr;
        logic [31:0] eaddr;
        logic        ers0, ers1;
        logic        wp;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[$];

    cacheline_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) req0_bus ();
    cacheline_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) req1_bus ();
    cacheline_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) pmem_bus ();

    cacheline_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0_bus),
        .req1 (req1_bus),
        .pmem (pmem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [LW-1:0] act, logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic void add(
        logic r, logic rd0, logic wr0, logic [31:0] a0,
        logic rd1, logic wr1, logic [31:0] a1, logic presp,
        logic eprd, logic epwr, logic [31:0] eaddr,
        logic ers0, logic ers1, logic wp
    );
        vec_t v;
        v.rst = r;
        v.rd0 = rd0; v.wr0 = wr0; v.a0 = a0;
        v.rd1 = rd1; v.wr1 = wr1; v.a1 = a1;
        v.presp = presp;
        v.eprd = eprd; v.epwr = epwr; v.eaddr = eaddr;
        v.ers0 = ers0; v.ers1 = ers1; v.wp = wp;
        vecs.push_back(v);
    endfunction

    task automatic idle_inputs();
        rst = 1'b0;
        req0_bus.mem_read = 1'b0;
        req0_bus.mem_write = 1'b0;
        req0_bus.mem_address = '0;
        req1_bus.mem_read = 1'b0;
        req1_bus.mem_write = 1'b0;
        req1_bus.mem_address = '0;
        pmem_bus.mem_resp = 1'b0;
    endtask

    initial begin
        logic [LW-1:0] ew;
        logic [BW-1:0] eb;
        int n;
        checks = 0;
        errors = 0;

        // rst rd0 wr0 a0 rd1 wr1 a1 presp | prd pwr addr rs0 rs1 wp
        for (int i = 0; i < 5; i++)
            add(0, 0,0,0, 0,0,0, 0,  0,0,0, 0,0,0);
        add(0, 1,0,32'h1000, 0,0,0, 0,  0,0,0,          0,0,0);
        add(0, 1,0,32'h1000, 0,0,0, 0,  1,0,32'h1000,   0,0,0);
        add(0, 1,0,32'h1000, 0,0,0, 0,  1,0,32'h1000,   0,0,0);
        add(0, 1,0,32'h1000, 0,0,0, 0,  1,0,32'h1000,   0,0,0);
        add(0, 1,0,32'h1000, 0,0,0, 1,  1,0,32'h1000,   1,0,0);
        add(0, 0,0,0, 0,0,0, 0,  0,0,0, 0,0,0);
        add(0, 0,0,0, 0,0,0, 0,  0,0,0, 0,0,0);
        add(1, 0,0,0, 0,0,0, 0,  0,0,0, 0,0,0);
        add(0, 1,0,32'h100, 0,1,32'h200, 0,  0,0,0,        0,0,0);
        add(0, 1,0,32'h100, 0,1,32'h200, 0,  1,0,32'h100,  0,0,0);
        add(0, 1,0,32'h100, 0,1,32'h200, 1,  1,0,32'h100,  1,0,0);
        add(0, 0,0,0, 0,1,32'h200, 0,  0,0,0,          0,0,0);
        add(0, 0,0,0, 0,1,32'h200, 0,  0,0,0,          0,0,0);
        add(0, 0,0,0, 0,1,32'h200, 0,  0,1,32'h200,    0,0,1);
        add(0, 0,0,0, 0,1,32'h200, 1,  0,1,32'h200,    0,1,1);
        add(0, 0,0,0, 0,0,0, 0,  0,0,0, 0,0,0);
        add(0, 0,0,0, 0,0,0, 0,  0,0,0, 0,0,0);
        add(0, 0,0,0, 1,0,32'h300, 0,  0,0,0,          0,0,0);
        add(0, 0,0,0, 1,0,32'h400, 0,  1,0,32'h300,    0,0,0);
        add(0, 0,0,0, 1,0,32'h400, 1,  1,0,32'h300,    0,1,0);
        add(0, 0,0,0, 0,0,0, 0,  0,0,0, 0,0,0);
        add(0, 0,0,0, 0,0,0, 0,  0,0,0, 0,0,0);
        add(0, 0,0,0, 0,0,0, 1,  0,0,0, 0,0,0);
        add(0, 1,0,32'h500, 0,0,0, 0,  0,0,0,          0,0,0);
        add(0, 1,0,32'h500, 0,0,0, 0,  1,0,32'h500,    0,0,0);
        add(1, 0,0,0, 0,0,0, 0,  1,0,32'h500,    0,0,0);
        add(0, 0,0,0, 0,0,0, 1,  0,0,0, 0,0,0);
        add(0, 1,0,32'h600, 1,0,32'h700, 0,  0,0,0,        0,0,0);
        add(0, 1,0,32'h600, 1,0,32'h700, 0,  1,0,32'h600,  0,0,0);
        add(0, 1,0,32'h600, 1,0,32'h700, 1,  1,0,32'h600,  1,0,0);
        add(0, 0,0,0, 1,0,32'h700, 0,  0,0,0,          0,0,0);
        add(0, 0,0,0, 1,0,32'h700, 0,  0,0,0,          0,0,0);
        add(0, 0,0,0, 1,0,32'h700, 0,  1,0,32'h700,    0,0,0);
        add(0, 0,0,0, 1,0,32'h700, 1,  1,0,32'h700,    0,1,0);
        add(0, 0,0,0, 0,0,0, 0,  0,0,0, 0,0,0);
        add(0, 1,1,32'h800, 0,0,0, 0,  0,0,0,          0,0,0);
        add(0, 1,1,32'h800, 0,0,0, 0,  0,1,32'h800,    0,0,0);
        add(0, 1,1,32'h800, 0,0,0, 1,  0,1,32'h800,    1,0,0);
        add(0, 0,0,0, 0,0,0, 0,  0,0,0, 0,0,0);
        add(0, 0,0,0, 1,0,32'h900, 0,  0,0,0,          0,0,0);
        add(0, 0,0,0, 0,0,0, 0,  1,0,32'h900,    0,0,0);
        add(0, 0,0,0, 0,0,0, 1,  1,0,32'h900,    0,1,0);
        add(0, 0,0,0, 0,0,0, 0,  0,0,0, 0,0,0);

        idle_inputs();
        req0_bus.mem_wdata = WD0;
        req0_bus.mem_byte_enable = BE0;
        req1_bus.mem_wdata = WD1;
        req1_bus.mem_byte_enable = BE1;
        pmem_bus.mem_rdata = RDATA;
        rst = 1'b1;
        step();
        step();

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            req0_bus.mem_read = vecs[i].rd0;
            req0_bus.mem_write = vecs[i].wr0;
            req0_bus.mem_address = vecs[i].a0;
            req1_bus.mem_read = vecs[i].rd1;
            req1_bus.mem_write = vecs[i].wr1;
            req1_bus.mem_address = vecs[i].a1;
            pmem_bus.mem_resp = vecs[i].presp;
            #1;
            chk($sformatf("row%0d pmem_read", i),
                LW'(pmem_bus.mem_read), LW'(vecs[i].eprd));
            chk($sformatf("row%0d pmem_write", i),
                LW'(pmem_bus.mem_write), LW'(vecs[i].epwr));
            chk($sformatf("row%0d pmem_addr", i),
                LW'(pmem_bus.mem_address), LW'(vecs[i].eaddr));
            chk($sformatf("row%0d resp0", i),
                LW'(req0_bus.mem_resp), LW'(vecs[i].ers0));
            chk($sformatf("row%0d resp1", i),
                LW'(req1_bus.mem_resp), LW'(vecs[i].ers1));
            chk($sformatf("row%0d rdata0", i),
                req0_bus.mem_rdata, vecs[i].ers0 ? RDATA : '0);
            chk($sformatf("row%0d rdata1", i),
                req1_bus.mem_rdata, vecs[i].ers1 ? RDATA : '0);
            if (vecs[i].epwr) begin
                ew = vecs[i].wp ? WD1 : WD0;
                eb = vecs[i].wp ? BE1 : BE0;
                chk($sformatf("row%0d pmem_wdata", i), pmem_bus.mem_wdata, ew);
                chk($sformatf("row%0d pmem_be", i),
                    LW'(pmem_bus.mem_byte_enable), LW'(eb));
            end
            step();
        end

        // Fairness: both ports hold reads; grants must alternate from port 0.
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_bus.mem_read = 1'b1;
        req0_bus.mem_address = 32'hA00;
        req1_bus.mem_read = 1'b1;
        req1_bus.mem_address = 32'hB00;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!pmem_bus.mem_read && n < 20) begin
                step();
                n++;
            end
            chk($sformatf("fair%0d strobe_seen", k),
                LW'(pmem_bus.mem_read), LW'(1'b1));
            if (k > 0)
                chk($sformatf("fair%0d gap_ge1", k), LW'(n >= 1), LW'(1'b1));
            chk($sformatf("fair%0d addr", k), LW'(pmem_bus.mem_address),
                LW'((k % 2 == 0) ? 32'hA00 : 32'hB00));
            step();
            step();
            pmem_bus.mem_resp = 1'b1;
            #1;
            chk($sformatf("fair%0d resp0", k),
                LW'(req0_bus.mem_resp), LW'(k % 2 == 0));
            chk($sformatf("fair%0d resp1", k),
                LW'(req1_bus.mem_resp), LW'(k % 2 == 1));
            step();
            pmem_bus.mem_resp = 1'b0;
            #1;
            chk($sformatf("fair%0d release_low", k),
                LW'(pmem_bus.mem_read), LW'(1'b0));
        end
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
